mem_write_arb: RTL and testbench
================================

MEM_WRITE_ARB -- requirements
Module: mem_write_arb

Interface
REQ-001 Parameter NUM_PORTS, default mem_pkg::NUM_WR_PORTS (4), number of write-controller requesters.
REQ-002 Parameter GNT_CNT_W, default 16, width of each per-port grant counter (stats build only).
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 wr_req_i  input  NUM_PORTS  per-port request for one block-write slot; level.
REQ-007 wr_ready_o  output  NUM_PORTS  one-hot grant pulse; connects to each write controller's mem_ready_i.
REQ-008 wr_we_i  input  NUM_PORTS  per-port write strobe from write controller.
REQ-009 wr_addr_i  input  NUM_PORTS x ADDR_W  per-port block index.
REQ-010 wr_wdata_i  input  NUM_PORTS x BLOCK_BITS  per-port block data (payload + footer).
REQ-011 mem_ready_i  input  1  buffer memory accepts a write this cycle.
REQ-012 mem_we_o  output  1  write strobe to buffer memory.
REQ-013 mem_addr_o  output  ADDR_W  write block index.
REQ-014 mem_wdata_o  output  BLOCK_BITS  write block data.
REQ-015 mem_src_o  output  clog2(NUM_PORTS)  index of the port that owns the current write.
REQ-016 err_o  output  1  sticky protocol error flag.

Function
REQ-017 FSM states ARB, GRANT, COLLECT, ISSUE; at most one write in flight.
REQ-018 ARB: if any wr_req_i set, pick port g by round-robin starting at rr_ptr; register g; go to GRANT; else stay in ARB.
REQ-019 GRANT: wr_ready_o = one-hot(g) for exactly this one cycle (driven from registered state, never combinationally from wr_req_i); go to COLLECT.
REQ-020 COLLECT: if wr_we_i[g], latch wr_addr_i[g] and wr_wdata_i[g] and go to ISSUE; else go to ARB with no write issued and rr_ptr = g+1 (requester abandoned slot).
REQ-021 ISSUE: mem_we_o=1 with latched addr/data and mem_src_o=g held stable until a cycle with mem_ready_i=1; that cycle completes the write; next state ARB, rr_ptr = g+1 mod NUM_PORTS.
REQ-022 Latency: wr_req_i sampled at cycle n -> wr_ready_o at n+1 -> wr_we_i at n+2 -> mem_we_o first asserted at n+3; minimum 4 cycles between grants.
REQ-023 wr_we_i on any port other than g during COLLECT, or any wr_we_i in ARB/GRANT/ISSUE, is ignored for the datapath and sets err_o.
REQ-024 Round-robin wraps from NUM_PORTS-1 to 0; a port holding wr_req_i continuously waits at most NUM_PORTS-1 other grants.
REQ-025 mem_addr_o, mem_wdata_o, mem_src_o are 0 whenever mem_we_o=0.
REQ-026 wr_req_i deasserted after grant has no effect on the current slot.

Reset
REQ-027 On rst_n low, immediately: state ARB, rr_ptr 0, wr_ready_o 0, mem_we_o 0, mem_addr_o 0, mem_wdata_o 0, mem_src_o 0, err_o 0, grant counters 0.
REQ-028 Reset during ISSUE drops the in-flight write; no partial write is retried after reset.

Configuration
REQ-029 Macro MEM_WR_ARB_STATS_EN defined: adds output gnt_cnt_o (NUM_PORTS x GNT_CNT_W), per-port count of completed writes (REQ-021), saturating at all-ones.
REQ-030 MEM_WR_ARB_STATS_EN undefined: gnt_cnt_o port and counters absent; all other behaviour identical.

Structure
REQ-031 mem_pkg holds NUM_WR_PORTS, ADDR_W, BLOCK_BITS and the enum type mem_wr_arb_state_t.
REQ-032 Round-robin selection is a sub-module rr_arbiter (request vector and pointer in, one-hot grant and index out, combinational).

Verification
REQ-033 Single request: wr_req_i=0001, port0 drives we at n+2 with addr 5 -> mem_we_o at n+3, mem_addr_o=5, mem_src_o=0.
REQ-034 All four requesting continuously, mem_ready_i=1 -> grant order 0,1,2,3,0, one grant every 4 cycles.
REQ-035 mem_ready_i held low 3 cycles in ISSUE -> mem_we_o and data stable 4 cycles, write counted once.
REQ-036 Granted port 2 withholds wr_we_i in COLLECT -> no mem_we_o, next grant goes to port 3.
REQ-037 Port 1 asserts wr_we_i while port 0 is granted -> err_o=1 sticky, port 0 data written unchanged.
REQ-038 rst_n low mid-ISSUE -> all outputs 0 same cycle; after release first grant goes to lowest requesting port from 0.

Source files
------------

// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg : shared sizes and write-arbiter state type for the buffer memory
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

  localparam int NUM_WR_PORTS = 4;
  localparam int ADDR_W       = 8;
  localparam int BLOCK_BITS   = 64;

  typedef enum logic [1:0] {
    ST_ARB     = 2'd0,
    ST_GRANT   = 2'd1,
    ST_COLLECT = 2'd2,
    ST_ISSUE   = 2'd3
  } mem_wr_arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, lowest request at or above ptr
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [N-1:0] w_req_hi;
  logic [N-1:0] w_pick;

  always_comb begin
    w_req_hi = '0;
    for (int j = 0; j < N; j++) begin
      w_req_hi[j] = req[j] && (j >= int'(ptr));
    end
  end

  // Requests at/above the pointer win; otherwise wrap to the lowest request.
  always_comb begin
    w_pick = (|w_req_hi) ? w_req_hi : req;
    gnt    = '0;
    idx    = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_pick[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
    valid = |req;
  end

endmodule

`default_nettype wire

// File: rtl/mem_write_arb.sv
// ----------------------------------------------------------------------------
// mem_write_arb : round-robin arbiter serialising block writes into the buffer
// memory, one write in flight. Optional MEM_WR_ARB_STATS_EN adds grant counters.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_write_arb
  import mem_pkg::*;
#(
  parameter int NUM_PORTS = NUM_WR_PORTS
`ifdef MEM_WR_ARB_STATS_EN
  , parameter int GNT_CNT_W = 16
`endif
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_PORTS-1:0]                   wr_req_i,
  output logic [NUM_PORTS-1:0]                   wr_ready_o,
  input  logic [NUM_PORTS-1:0]                   wr_we_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]       wr_addr_i,
  input  logic [NUM_PORTS-1:0][BLOCK_BITS-1:0]   wr_wdata_i,
  input  logic                                   mem_ready_i,
  output logic                                   mem_we_o,
  output logic [ADDR_W-1:0]                      mem_addr_o,
  output logic [BLOCK_BITS-1:0]                  mem_wdata_o,
  output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] mem_src_o,
  output logic                                   err_o
`ifdef MEM_WR_ARB_STATS_EN
  , output logic [NUM_PORTS-1:0][GNT_CNT_W-1:0]  gnt_cnt_o
`endif
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  mem_wr_arb_state_t       r_state;
  mem_wr_arb_state_t       w_next_state;
  logic [IDX_W-1:0]        r_ptr;
  logic [IDX_W-1:0]        r_gnt_idx;
  logic [NUM_PORTS-1:0]    r_gnt_oh;
  logic [ADDR_W-1:0]       r_addr;
  logic [BLOCK_BITS-1:0]   r_wdata;
  logic                    r_err;

  logic [NUM_PORTS-1:0]    w_arb_gnt;
  logic [IDX_W-1:0]        w_arb_idx;
  logic                    w_arb_valid;
  logic [NUM_PORTS-1:0]    w_allowed_we;
  logic                    w_collect_hit;
  logic [IDX_W-1:0]        w_ptr_next;

  rr_arbiter #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req   (wr_req_i),
    .ptr   (r_ptr),
    .gnt   (w_arb_gnt),
    .idx   (w_arb_idx),
    .valid (w_arb_valid)
  );

  assign w_collect_hit = |(wr_we_i & r_gnt_oh);
  assign w_ptr_next    = (r_gnt_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : r_gnt_idx + IDX_W'(1);

  always_comb begin
    w_next_state = r_state;
    wr_ready_o   = '0;
    mem_we_o     = 1'b0;
    w_allowed_we = '0;
    case (r_state)
      ST_ARB:     if (w_arb_valid) w_next_state = ST_GRANT;
      ST_GRANT: begin
        wr_ready_o   = r_gnt_oh;
        w_next_state = ST_COLLECT;
      end
      ST_COLLECT: begin
        w_allowed_we = r_gnt_oh;
        w_next_state = w_collect_hit ? ST_ISSUE : ST_ARB;
      end
      ST_ISSUE: begin
        mem_we_o = 1'b1;
        if (mem_ready_i) w_next_state = ST_ARB;
      end
      default:    w_next_state = ST_ARB;
    endcase
    mem_addr_o  = mem_we_o ? r_addr    : '0;
    mem_wdata_o = mem_we_o ? r_wdata   : '0;
    mem_src_o   = mem_we_o ? r_gnt_idx : '0;
  end

  assign err_o = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_ARB;
      r_ptr     <= '0;
      r_gnt_idx <= '0;
      r_gnt_oh  <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_err   <= r_err | (|(wr_we_i & ~w_allowed_we));
      case (r_state)
        ST_ARB: begin
          if (w_arb_valid) begin
            r_gnt_idx <= w_arb_idx;
            r_gnt_oh  <= w_arb_gnt;
          end
        end
        ST_COLLECT: begin
          if (w_collect_hit) begin
            r_addr  <= wr_addr_i[r_gnt_idx];
            r_wdata <= wr_wdata_i[r_gnt_idx];
          end else begin
            r_ptr <= w_ptr_next;
          end
        end
        ST_ISSUE: begin
          if (mem_ready_i) begin
            r_ptr   <= w_ptr_next;
            r_addr  <= '0;
            r_wdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_WR_ARB_STATS_EN
  logic w_wr_done;
  assign w_wr_done = (r_state == ST_ISSUE) && mem_ready_i;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt
    logic [GNT_CNT_W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_wr_done && (r_gnt_idx == IDX_W'(p)) && (r_cnt != '1)) begin
        r_cnt <= r_cnt + GNT_CNT_W'(1);
      end
    end
    assign gnt_cnt_o[p] = r_cnt;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_write_arb.sv
// ----------------------------------------------------------------------------
// tb_mem_write_arb : directed self-checking bench for mem_write_arb
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_write_arb;
  import mem_pkg::*;

  localparam int NP = NUM_WR_PORTS;

  logic                             clk = 1'b0;
  logic                             rst_n;
  logic [NP-1:0]                    wr_req;
  logic [NP-1:0]                    wr_ready;
  logic [NP-1:0]                    wr_we;
  logic [NP-1:0][ADDR_W-1:0]        wr_addr;
  logic [NP-1:0][BLOCK_BITS-1:0]    wr_wdata;
  logic                             mem_ready;
  logic                             mem_we;
  logic [ADDR_W-1:0]                mem_addr;
  logic [BLOCK_BITS-1:0]            mem_wdata;
  logic [$clog2(NP)-1:0]            mem_src;
  logic                             err;
`ifdef MEM_WR_ARB_STATS_EN
  logic [NP-1:0][15:0]              gnt_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_write_arb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_req_i    (wr_req),
    .wr_ready_o  (wr_ready),
    .wr_we_i     (wr_we),
    .wr_addr_i   (wr_addr),
    .wr_wdata_i  (wr_wdata),
    .mem_ready_i (mem_ready),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_src_o   (mem_src),
    .err_o       (err)
`ifdef MEM_WR_ARB_STATS_EN
    , .gnt_cnt_o (gnt_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, wr_ready, 0);
    chk({tag, "_we"},    mem_we,   0);
    chk({tag, "_addr"},  mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_src"},   mem_src,  0);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    wr_req = '0;
    wr_we  = '0;
    tick();
    tick();
    rst_n  = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    wr_req    = '0;
    wr_we     = '0;
    wr_addr   = '0;
    wr_wdata  = '0;
    #2 rst_n  = 1'b0;
    #1;
    chk_idle("reset");
    chk("reset_err", err, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single request from port 0, addr 5
    wr_req      = 4'b0001;
    wr_addr[0]  = 8'd5;
    wr_wdata[0] = 64'hCAFE_0000_0000_0005;
    tick();
    chk("single_grant", wr_ready, 4'b0001);
    chk("single_we_early", mem_we, 0);
    wr_req = '0;
    tick();
    chk("single_ready_pulse", wr_ready, 0);
    wr_we = 4'b0001;
    tick();
    wr_we = '0;
    chk("single_mem_we", mem_we, 1);
    chk("single_addr", mem_addr, 8'd5);
    chk("single_wdata", mem_wdata, 64'hCAFE_0000_0000_0005);
    chk("single_src", mem_src, 0);
    tick();
    chk_idle("single_done");
    chk("single_err", err, 0);

    // All four requesting: 0,1,2,3,0 with one grant every 4 cycles
    do_reset();
    for (int p = 0; p < NP; p++) begin
      wr_addr[p]  = 8'h10 + 8'(p);
      wr_wdata[p] = 64'h1000 + 64'(p);
    end
    wr_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_grant", wr_ready, 4'b0001 << (k % NP));
      tick();
      wr_we = 4'b0001 << (k % NP);
      tick();
      wr_we = '0;
      chk("rr_src", mem_src, k % NP);
      chk("rr_addr", mem_addr, 8'h10 + 8'(k % NP));
      tick();
      chk("rr_arb_gap", wr_ready, 0);
    end
    wr_req = '0;

    // Memory stall: ready low for 3 ISSUE cycles
    wr_req      = 4'b0100;
    mem_ready   = 1'b0;
    wr_addr[2]  = 8'h77;
    wr_wdata[2] = 64'hBEEF_0000_0000_0077;
    tick();
    chk("stall_grant", wr_ready, 4'b0100);
    wr_req = '0;
    tick();
    wr_we = 4'b0100;
    tick();
    wr_we = '0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_we", mem_we, 1);
      chk("stall_addr", mem_addr, 8'h77);
      chk("stall_wdata", mem_wdata, 64'hBEEF_0000_0000_0077);
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    chk("stall_done_we", mem_we, 0);
`ifdef MEM_WR_ARB_STATS_EN
    chk("stall_cnt2", gnt_cnt[2], 2);
    chk("stall_cnt0", gnt_cnt[0], 2);
`endif

    // Port 2 abandons its slot; next grant goes to port 3
    wr_req = 4'b0100;
    tick();
    chk("abandon_grant", wr_ready, 4'b0100);
    wr_req = 4'b1111;
    tick();
    tick();
    chk("abandon_no_we", mem_we, 0);
    chk("abandon_arb_ready", wr_ready, 0);
    tick();
    chk("abandon_next", wr_ready, 4'b1000);
    tick();
    tick();
    wr_req = '0;
    chk("abandon_err", err, 0);

    // Port 1 strobes while port 0 holds the slot
    wr_req      = 4'b0001;
    wr_addr[0]  = 8'h11;
    wr_wdata[0] = 64'hAAAA_0000_0000_0011;
    wr_addr[1]  = 8'h22;
    wr_wdata[1] = 64'h5555_0000_0000_0022;
    tick();
    chk("err_grant", wr_ready, 4'b0001);
    wr_req = '0;
    tick();
    wr_we = 4'b0011;
    tick();
    wr_we = '0;
    chk("err_addr", mem_addr, 8'h11);
    chk("err_wdata", mem_wdata, 64'hAAAA_0000_0000_0011);
    chk("err_src", mem_src, 0);
    chk("err_set", err, 1);
    tick();
    chk("err_sticky", err, 1);

    // Advance pointer to 2, then reset with port 3 in ISSUE
    wr_req = 4'b0010;
    tick();
    chk("pre_rst_grant", wr_ready, 4'b0010);
    wr_req = '0;
    tick();
    wr_we = 4'b0010;
    tick();
    wr_we = '0;
    tick();
    wr_req    = 4'b1000;
    mem_ready = 1'b0;
    tick();
    chk("pre_rst_grant3", wr_ready, 4'b1000);
    wr_req = '0;
    tick();
    wr_we = 4'b1000;
    tick();
    wr_we = '0;
    chk("pre_rst_issue", mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("midrst");
    chk("midrst_err", err, 0);
`ifdef MEM_WR_ARB_STATS_EN
    chk("midrst_cnt0", gnt_cnt[0], 0);
`endif
    tick();
    mem_ready = 1'b1;
    rst_n     = 1'b1;
    wr_req    = 4'b0110;
    tick();
    chk("post_rst_grant", wr_ready, 4'b0010);
    chk("post_rst_no_we", mem_we, 0);
    wr_req = '0;
    tick();
    tick();
    chk("post_rst_abandon", mem_we, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
